cnn_win3x3_gen: RTL and testbench

- Downstream of the CNN frame timing controller.
- Consumes its data-run strobe, row/col indices, end-of-frame flag and the pixel stream, and produces zero-padded 3x3 convolution windows, one per pixel, in raster order.
- Keeps two line buffers for the previous rows. After each line it emits the right-edge window, and after the frame it flushes the bottom row.

---
 rtl/cnn_win3x3_gen.sv | 217 +++++++++++++++++++++
 tb/tb_cnn_win3x3_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_win3x3_gen.sv
// rtl/cnn_win3x3_gen.sv - 3x3 raster window generator with two line buffers and edge/bottom flush
// Build option: define WIN_REPLICATE_PAD_EN for edge-replicating padding instead of zero padding.
module cnn_win3x3_gen #(
    parameter int W_SIZE    = 12,
    parameter int W_DATA    = 8,
    parameter int MAX_WIDTH = 2048
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [W_SIZE-1:0]     q_width,
    input  logic [W_SIZE-1:0]     q_height,
    input  logic                  i_data_run,
    input  logic [W_SIZE-1:0]     i_row,
    input  logic [W_SIZE-1:0]     i_col,
    input  logic                  i_end_frame,
    input  logic [W_DATA-1:0]     i_pixel,
    output logic                  o_win_valid,
    output logic [9*W_DATA-1:0]   o_win,
    output logic [W_SIZE-1:0]     o_win_row,
    output logic [W_SIZE-1:0]     o_win_col,
    output logic                  o_win_last,
    output logic                  o_busy,
    output logic                  o_overrun
);
    localparam int W_ADDR = $clog2(MAX_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_EDGE, S_FLUSH} state_t;
    typedef logic [2:0][W_DATA-1:0] col_t;

    state_t state_q, state_d;

    logic [W_DATA-1:0] lb0_mem [MAX_WIDTH];
    logic [W_DATA-1:0] lb1_mem [MAX_WIDTH];

    col_t               sr1_q, sr2_q, rd_col;
    logic [W_SIZE-1:0]  wm1_q, hm1_q, row_q, fcnt_q;
    logic               eof_q, overrun_q, busy_q, valid_q, last_q;
    logic [W_SIZE-1:0]  win_row_q, win_col_q;
    logic [9*W_DATA-1:0] win_q, win_d;

    logic               acc, in_col;
    logic [W_SIZE-1:0]  wm1, rd_idx, row_d, col_d;
    logic               emit_d, last_d;
    logic               pad_top, pad_bot, pad_left, pad_right;
    logic [W_DATA-1:0]  tap [3][3];

    assign acc = i_data_run && (state_q == S_IDLE || state_q == S_RUN);
    assign wm1 = (state_q == S_IDLE) ? q_width - W_SIZE'(1) : wm1_q;

    // One read port per buffer: the accepted column, column 0 preload in EDGE, or the next flush column.
    always_comb begin
        rd_idx = fcnt_q + W_SIZE'(1);
        if (acc) begin
            rd_idx = i_col;
        end else if (state_q == S_EDGE) begin
            rd_idx = '0;
        end
    end

    assign in_col    = (rd_idx <= wm1);
    assign rd_col[0] = in_col ? lb1_mem[rd_idx[W_ADDR-1:0]] : '0;
    assign rd_col[1] = in_col ? lb0_mem[rd_idx[W_ADDR-1:0]] : '0;
    assign rd_col[2] = acc ? i_pixel : '0;

    always_ff @(posedge clk) begin
        if (rstn && acc) begin
            lb0_mem[rd_idx[W_ADDR-1:0]] <= i_pixel;
            lb1_mem[rd_idx[W_ADDR-1:0]] <= lb0_mem[rd_idx[W_ADDR-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (acc) begin
                    state_d = (i_row != '0 && i_col == wm1) ? S_EDGE : S_RUN;
                end
            end
            S_EDGE:  state_d = eof_q ? S_FLUSH : S_RUN;
            S_FLUSH: if (fcnt_q == wm1_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        emit_d    = 1'b0;
        last_d    = 1'b0;
        row_d     = win_row_q;
        col_d     = win_col_q;
        pad_top   = 1'b0;
        pad_bot   = 1'b0;
        pad_left  = 1'b0;
        pad_right = 1'b0;
        case (state_q)
            S_IDLE, S_RUN: begin
                emit_d   = acc && i_row != '0 && i_col != '0;
                row_d    = i_row - W_SIZE'(1);
                col_d    = i_col - W_SIZE'(1);
                pad_top  = (i_row == W_SIZE'(1));
                pad_left = (i_col == W_SIZE'(1));
            end
            S_EDGE: begin
                emit_d    = 1'b1;
                row_d     = row_q - W_SIZE'(1);
                col_d     = wm1_q;
                pad_top   = (row_q == W_SIZE'(1));
                pad_right = 1'b1;
            end
            S_FLUSH: begin
                emit_d    = 1'b1;
                row_d     = hm1_q;
                col_d     = fcnt_q;
                last_d    = (fcnt_q == wm1_q);
                pad_left  = (fcnt_q == '0);
                pad_right = (fcnt_q == wm1_q);
                pad_bot   = 1'b1;
            end
            default: ;
        endcase
    end

    // Window columns are older register, newer register, freshly read column (left to right).
    always_comb begin
        for (int dy = 0; dy < 3; dy++) begin
            tap[dy][0] = sr1_q[dy];
            tap[dy][1] = sr2_q[dy];
            tap[dy][2] = rd_col[dy];
        end
`ifdef WIN_REPLICATE_PAD_EN
        for (int dx = 0; dx < 3; dx++) begin
            if (pad_top) tap[0][dx] = tap[1][dx];
            if (pad_bot) tap[2][dx] = tap[1][dx];
        end
        for (int dy = 0; dy < 3; dy++) begin
            if (pad_left)  tap[dy][0] = tap[dy][1];
            if (pad_right) tap[dy][2] = tap[dy][1];
        end
`else
        for (int dx = 0; dx < 3; dx++) begin
            if (pad_top) tap[0][dx] = '0;
            if (pad_bot) tap[2][dx] = '0;
        end
        for (int dy = 0; dy < 3; dy++) begin
            if (pad_left)  tap[dy][0] = '0;
            if (pad_right) tap[dy][2] = '0;
        end
`endif
        win_d = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                win_d[(3*dy+dx)*W_DATA +: W_DATA] = tap[dy][dx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sr1_q     <= '0;
            sr2_q     <= '0;
            wm1_q     <= '0;
            hm1_q     <= '0;
            row_q     <= '0;
            fcnt_q    <= '0;
            eof_q     <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            win_q     <= '0;
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            if (acc || state_q == S_EDGE || state_q == S_FLUSH) begin
                sr1_q <= sr2_q;
                sr2_q <= rd_col;
            end
            if (acc) begin
                row_q <= i_row;
                eof_q <= i_end_frame;
            end
            if (acc && state_q == S_IDLE) begin
                wm1_q <= q_width - W_SIZE'(1);
                hm1_q <= q_height - W_SIZE'(1);
            end
            fcnt_q <= (state_q == S_FLUSH) ? fcnt_q + W_SIZE'(1) : '0;
            if (i_data_run && (state_q == S_EDGE || state_q == S_FLUSH)) begin
                overrun_q <= 1'b1;
            end
            busy_q  <= (state_q != S_IDLE);
            valid_q <= emit_d;
            last_q  <= emit_d && last_d;
            if (emit_d) begin
                win_q     <= win_d;
                win_row_q <= row_d;
                win_col_q <= col_d;
            end
        end
    end

    assign o_win_valid = valid_q;
    assign o_win       = win_q;
    assign o_win_row   = win_row_q;
    assign o_win_col   = win_col_q;
    assign o_win_last  = last_q;
    assign o_busy      = busy_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_cnn_win3x3_gen.sv
// tb/tb_cnn_win3x3_gen.sv - scoreboard bench for cnn_win3x3_gen on a 4x3 frame
module tb_cnn_win3x3_gen;
    localparam int W_SIZE = 12;
    localparam int W_DATA = 8;
    localparam int MAX_WIDTH = 2048;
    localparam int W = 4;
    localparam int H = 3;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [W_SIZE-1:0]    q_width, q_height, i_row, i_col;
    logic                 i_data_run, i_end_frame;
    logic [W_DATA-1:0]    i_pixel;
    logic                 o_win_valid, o_win_last, o_busy, o_overrun;
    logic [9*W_DATA-1:0]  o_win;
    logic [W_SIZE-1:0]    o_win_row, o_win_col;

    cnn_win3x3_gen #(.W_SIZE(W_SIZE), .W_DATA(W_DATA), .MAX_WIDTH(MAX_WIDTH)) dut (
        .clk(clk), .rstn(rstn), .q_width(q_width), .q_height(q_height),
        .i_data_run(i_data_run), .i_row(i_row), .i_col(i_col),
        .i_end_frame(i_end_frame), .i_pixel(i_pixel),
        .o_win_valid(o_win_valid), .o_win(o_win), .o_win_row(o_win_row),
        .o_win_col(o_win_col), .o_win_last(o_win_last), .o_busy(o_busy),
        .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           row;
        int           col;
        logic [71:0]  win;
        bit           last;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   last_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int pix(input int r, input int c);
        return 16 * r + c + 1;
    endfunction

    function automatic logic [71:0] pk9(input int t0, input int t1, input int t2,
                                         input int t3, input int t4, input int t5,
                                         input int t6, input int t7, input int t8);
        logic [71:0] w;
        w = {t8[7:0], t7[7:0], t6[7:0], t5[7:0], t4[7:0], t3[7:0], t2[7:0], t1[7:0], t0[7:0]};
        return w;
    endfunction

    function automatic logic [71:0] model_win(input int cr, input int cc);
        logic [71:0] w;
        int r;
        int c;
        int v;
        w = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                r = cr - 1 + dy;
                c = cc - 1 + dx;
`ifdef WIN_REPLICATE_PAD_EN
                if (r < 0) r = 0;
                if (r > H - 1) r = H - 1;
                if (c < 0) c = 0;
                if (c > W - 1) c = W - 1;
                v = pix(r, c);
`else
                v = (r < 0 || r > H - 1 || c < 0 || c > W - 1) ? 0 : pix(r, c);
`endif
                w[(3*dy+dx)*8 +: 8] = v[7:0];
            end
        end
        return w;
    endfunction

    task automatic push_win(input int r, input int c, input int at, input bit last);
        exp_t e;
        e.row = r;
        e.col = c;
        e.win = model_win(r, c);
        e.last = last;
        e.cyc = at;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (last_seen) begin
            check("busy_fall", 72'(o_busy), 72'(0));
            last_seen = 1'b0;
        end
        if (o_win_valid) begin
            if (sb.size() == 0) begin
                check("spurious_win", 72'(o_win_valid), 72'(0));
            end else begin
                e = sb.pop_front();
                check("win_row", 72'(o_win_row), 72'(e.row));
                check("win_col", 72'(o_win_col), 72'(e.col));
                check("win_taps", o_win, e.win);
                check("win_last", 72'(o_win_last), 72'(e.last));
                check("win_cycle", 72'(cyc), 72'(e.cyc));
`ifdef WIN_REPLICATE_PAD_EN
                if (e.row == 0 && e.col == 0)
                    check("w00_lit", o_win, pk9(1, 1, 2, 1, 1, 2, 17, 17, 18));
`else
                if (e.row == 0 && e.col == 0)
                    check("w00_lit", o_win, pk9(0, 0, 0, 0, 1, 2, 0, 17, 18));
                if (e.row == 0 && e.col == 3)
                    check("w03_lit", o_win, pk9(0, 0, 0, 3, 4, 0, 19, 20, 0));
                if (e.row == 2 && e.col == 3)
                    check("w23_lit", o_win, pk9(19, 20, 0, 35, 36, 0, 0, 0, 0));
`endif
                if (e.last) begin
                    check("busy_last", 72'(o_busy), 72'(1));
                    last_seen = 1'b1;
                end
            end
        end
    end

    task automatic check_zero(input string pfx);
        check({pfx, "_valid"}, 72'(o_win_valid), 72'(0));
        check({pfx, "_win"}, o_win, 72'(0));
        check({pfx, "_row"}, 72'(o_win_row), 72'(0));
        check({pfx, "_col"}, 72'(o_win_col), 72'(0));
        check({pfx, "_last"}, 72'(o_win_last), 72'(0));
        check({pfx, "_busy"}, 72'(o_busy), 72'(0));
        check({pfx, "_ovr"}, 72'(o_overrun), 72'(0));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("drain", 72'(sb.size()), 72'(0));
        repeat (2) @(posedge clk);
        #3;
    endtask

    task automatic drive_frame(input bit ovr, input bit abort);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                @(negedge clk);
                if (abort && r == 1 && c == 2) begin
                    i_data_run = 1'b0;
                    rstn = 1'b0;
                    @(posedge clk);
                    #2;
                    check_zero("abort");
                    @(negedge clk);
                    rstn = 1'b1;
                    check("abort_queue", 72'(sb.size()), 72'(0));
                    sb.delete();
                    return;
                end
                i_data_run  = 1'b1;
                i_row       = W_SIZE'(r);
                i_col       = W_SIZE'(c);
                i_pixel     = W_DATA'(pix(r, c));
                i_end_frame = (r == H - 1 && c == W - 1);
                if (r >= 1 && c >= 1) push_win(r - 1, c - 1, cyc + 1, 1'b0);
                if (r >= 1 && c == W - 1) push_win(r - 1, W - 1, cyc + 2, 1'b0);
                if (r == H - 1 && c == W - 1) begin
                    for (int k = 0; k < W; k++) push_win(H - 1, k, cyc + 3 + k, k == W - 1);
                end
            end
            @(negedge clk);
            i_data_run  = 1'b0;
            i_end_frame = 1'b0;
        end
        if (ovr) begin
            for (int k = 0; k < W; k++) begin
                @(negedge clk);
                i_data_run = 1'b1;
                i_row      = W_SIZE'(1);
                i_col      = W_SIZE'(W - 1 - k);
                i_pixel    = 8'hEE;
            end
            @(negedge clk);
            i_data_run = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, %0d windows still pending", sb.size());
        $fatal(1);
    end

    initial begin
        rstn        = 1'b0;
        q_width     = W_SIZE'(W);
        q_height    = W_SIZE'(H);
        i_data_run  = 1'b0;
        i_row       = '0;
        i_col       = '0;
        i_end_frame = 1'b0;
        i_pixel     = '0;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        drive_frame(1'b0, 1'b0);
        check("ovr_clear", 72'(o_overrun), 72'(0));
        drive_frame(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        drive_frame(1'b0, 1'b0);
        check("ovr_clear2", 72'(o_overrun), 72'(0));
        drive_frame(1'b1, 1'b0);
        check("ovr_set", 72'(o_overrun), 72'(1));
        repeat (5) @(negedge clk);
        check("ovr_sticky", 72'(o_overrun), 72'(1));
        check("idle_busy", 72'(o_busy), 72'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
